pipe_scroller: RTL

//  Multi-channel obstacle generator for the Flappy Bird playfield. It owns NUM_PIPES pipes and scrolls

---
 rtl/pipe_scroller.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/pipe_scroller.sv
// pipe_scroller: scrolls NUM_PIPES pipe obstacles leftward once per frame,
// respawns them on the right with an LFSR-chosen gap height, reports bird passes.
module pipe_scroller #(
  parameter int unsigned NUM_PIPES  = 4,
  parameter int unsigned XW         = 11,
  parameter int unsigned X_START    = 640,
  parameter int unsigned SPACING    = 160,
  parameter int unsigned GAP_Y_MIN  = 140,
  parameter int unsigned GAP_Y_SPAN = 200,
  parameter int unsigned SPEED_BASE = 1,
  parameter int unsigned SPEED_DIV  = 1000,
  parameter int unsigned SPEED_MAX  = 6
) (
  input  logic                    frame_clk,
  input  logic                    Reset,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    game_over,
  input  logic [26:0]             score,
  input  logic [XW-1:0]           bird_x,
  output logic [NUM_PIPES*XW-1:0] pipe_x,
  output logic [NUM_PIPES*10-1:0] gap_y,
  output logic [2:0]              speed,
  output logic [1:0]              state,
  output logic                    pass_pulse
);

  localparam int unsigned GW      = 10;
  localparam int unsigned LW      = 16;
  localparam int unsigned WRAP    = NUM_PIPES * SPACING;
  localparam int unsigned GAP_MID = GAP_Y_MIN + GAP_Y_SPAN / 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_OVER   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   lfsr_q, lfsr_d;
  logic            pass_q, pass_d;
  logic [XW-1:0]   x_q   [NUM_PIPES];
  logic [XW-1:0]   x_d   [NUM_PIPES];
  logic [GW-1:0]   gap_q [NUM_PIPES];
  logic [GW-1:0]   gap_d [NUM_PIPES];
  logic            move_c;
  logic            load_c;
  logic [26:0]     score_div;

  // Gap offset for a respawning pipe: byte of the rotated LFSR, folded into the span.
  function automatic logic [7:0] respawn_r(input logic [LW-1:0] v, input int unsigned n);
    logic [7:0] b;
    b = 8'(({v, v} << (n % LW)) >> LW);
    if ({1'b0, b} >= 9'(GAP_Y_SPAN)) begin
      b = b - 8'(GAP_Y_SPAN);
    end
    return b;
  endfunction

  // Scroll speed from score, clamped at the ceiling.
  assign score_div = score / 27'(SPEED_DIV);
  always_comb begin
    speed = 3'(SPEED_MAX);
    if (score_div < 27'(SPEED_MAX - SPEED_BASE)) begin
      speed = 3'(SPEED_BASE) + score_div[2:0];
    end
  end

  // Game-state next-state logic; game_over outranks pause, which outranks start.
  always_comb begin
    state_d = state_q;
    move_c  = 1'b0;
    load_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (game_over)  state_d = ST_OVER;
        else if (pause) state_d = ST_PAUSED;
        else            move_c  = 1'b1;
      end
      ST_PAUSED: begin
        if (game_over)   state_d = ST_OVER;
        else if (!pause) state_d = ST_RUN;
      end
      ST_OVER: begin
        if (start) begin
          load_c  = 1'b1;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pipe motion, respawn, pass detection and free-running LFSR.
  always_comb begin
    lfsr_d = {lfsr_q[LW-2:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    pass_d = 1'b0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      x_d[i]   = x_q[i];
      gap_d[i] = gap_q[i];
    end
    if (load_c) begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        x_d[i]   = XW'(X_START + i * SPACING);
        gap_d[i] = GW'(GAP_MID);
      end
    end else if (move_c) begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        // old x >= bird_x and x - speed < bird_x, without underflow
        if ((x_q[i] >= bird_x) &&
            ({1'b0, x_q[i]} < ({1'b0, bird_x} + (XW+1)'(speed)))) begin
          pass_d = 1'b1;
        end
        if (x_q[i] >= XW'(speed)) begin
          x_d[i] = x_q[i] - XW'(speed);
        end else begin
          x_d[i]   = x_q[i] + XW'(WRAP) - XW'(speed);
          gap_d[i] = GW'(GAP_Y_MIN) + GW'(respawn_r(lfsr_q, 3 * i));
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      lfsr_q  <= 16'hACE1;
      pass_q  <= 1'b0;
      for (int i = 0; i < NUM_PIPES; i++) begin
        x_q[i]   <= XW'(X_START + i * SPACING);
        gap_q[i] <= GW'(GAP_MID);
      end
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      pass_q  <= pass_d;
      for (int i = 0; i < NUM_PIPES; i++) begin
        x_q[i]   <= x_d[i];
        gap_q[i] <= gap_d[i];
      end
    end
  end

  // Pack per-pipe registers onto the output buses.
  always_comb begin
    pipe_x = '0;
    gap_y  = '0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      pipe_x[i*XW +: XW] = x_q[i];
      gap_y[i*GW +: GW]  = gap_q[i];
    end
  end

  assign state      = state_q;
  assign pass_pulse = pass_q;

endmodule
